// File: rtl/spram_burst_controller.sv
// spram_burst_controller
//   Presents NUM_BANKS single-port SPRAM macros as one linear 16-bit word
//   memory behind a burst command port.
// Ports:
//   clk, reset              clock, async active-high reset
//   cmd_valid/ready         command handshake; cmd_write, cmd_addr (byte), cmd_len (words)
//   wr_data/valid/ready     write beat stream
//   rd_data/rd_valid        read beats, two cycles after issue, no backpressure
//   busy                    burst active or read data still in flight
//   done                    one-cycle pulse at burst completion

// Behavioural stand-in for the SB_SPRAM256KA macro. It has the same pin names
// and a one-cycle registered read, so the real primitive drops in unchanged.
module spram_bank (
    input  logic        CLOCK,
    input  logic [13:0] ADDRESS,
    input  logic [15:0] DATAIN,
    input  logic [3:0]  MASKWREN,
    input  logic        WREN,
    input  logic        CHIPSELECT,
    input  logic        STANDBY,
    input  logic        SLEEP,
    input  logic        POWEROFF,
    output logic [15:0] DATAOUT
);
    logic [15:0] mem [16384];
    logic        en;

    assign en = CHIPSELECT & ~STANDBY & ~SLEEP & POWEROFF;

    always_ff @(posedge CLOCK) begin
        if (en) begin
            if (WREN) begin
                for (int n = 0; n < 4; n++)
                    if (MASKWREN[n]) mem[ADDRESS][n*4 +: 4] <= DATAIN[n*4 +: 4];
            end else begin
                DATAOUT <= mem[ADDRESS];
            end
        end
    end
endmodule

module spram_burst_controller #(
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [15:0]       wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done
);
    localparam int LB        = $clog2(NUM_BANKS);
    localparam int BANK_W    = (LB > 0) ? LB : 1;
    localparam int WA_W      = 14 + LB;
    localparam int RD_STAGES = 2;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    // Side information that travels with each read down the pipeline.
    typedef struct packed {
        logic              last;
        logic [BANK_W-1:0] bank;
    } rd_tag_t;

    state_t                       state, state_nxt;
    logic [WA_W-1:0]              wa;
    logic [LEN_W-1:0]             rem;
    logic                         zdone_q, wdone_q;
    logic [RD_STAGES-1:0]         vld_pipe;
    rd_tag_t [RD_STAGES-1:0]      tag_pipe;
    logic [NUM_BANKS-1:0][15:0]   bank_dout;
    logic [NUM_BANKS-1:0]         bank_wren;
    logic [BANK_W-1:0]            cur_bank;
    logic [WA_W-1:0]              cmd_wa;
    logic                         cmd_fire, wr_fire, rd_issue, last_beat;
    logic                         unused_addr_bits;

    assign cmd_wa           = cmd_addr[WA_W:1];
    assign unused_addr_bits = ^{cmd_addr[ADDR_W-1:WA_W+1], cmd_addr[0]};
    assign cur_bank         = BANK_W'(wa >> 14);
    assign last_beat        = (rem == LEN_W'(1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (cmd_fire && cmd_len != '0) state_nxt = cmd_write ? WRITE : READ;
            WRITE: if (wr_valid && last_beat)     state_nxt = IDLE;
            READ:  if (last_beat)                 state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    // Outputs / strobes. cmd_ready drops while a zero-length done is pending.
    always_comb begin
        cmd_ready = (state == IDLE) && !zdone_q;
        wr_ready  = (state == WRITE);
        cmd_fire  = cmd_valid && cmd_ready;
        wr_fire   = (state == WRITE) && wr_valid;
        rd_issue  = (state == READ);
    end

    // Address / length tracking. WA wraps naturally at WA_W bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wa      <= '0;
            rem     <= '0;
            zdone_q <= 1'b0;
            wdone_q <= 1'b0;
        end else begin
            zdone_q <= cmd_fire && (cmd_len == '0);
            wdone_q <= wr_fire && last_beat;
            if (cmd_fire) begin
                wa  <= cmd_wa;
                rem <= cmd_len;
            end else if (wr_fire || rd_issue) begin
                wa  <= wa + 1'b1;
                rem <= rem - 1'b1;
            end
        end
    end

    // Read return pipe: stage 0 = macro output valid, stage 1 = rd_data valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
            rd_data  <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[0], rd_issue};
            tag_pipe[0] <= '{last: last_beat, bank: cur_bank};
            tag_pipe[1] <= tag_pipe[0];
            if (vld_pipe[0]) rd_data <= bank_dout[tag_pipe[0].bank];
        end
    end

    assign rd_valid = vld_pipe[1];
    assign done     = zdone_q || wdone_q || (vld_pipe[1] && tag_pipe[1].last);
    assign busy     = (state != IDLE) || (|vld_pipe);

    // All banks share address/data; only the addressed bank is write-enabled.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_wren[b] = wr_fire && (cur_bank == BANK_W'(b));
        spram_bank u_bank (
            .CLOCK     (clk),
            .ADDRESS   (wa[13:0]),
            .DATAIN    (wr_data),
            .MASKWREN  (4'b1111),
            .WREN      (bank_wren[b]),
            .CHIPSELECT(1'b1),
            .STANDBY   (1'b0),
            .SLEEP     (1'b0),
            .POWEROFF  (1'b1),
            .DATAOUT   (bank_dout[b])
        );
    end
endmodule

// File: doc/spram_burst_controller.md
Name: spram_burst_controller

Overview:
Parametrised successor to the single-access SPRAM front end. It presents NUM_BANKS SB_SPRAM256KA macros as one linear 16-bit word memory behind a burst command port. A command carries a byte address, a length and a direction. Write data is streamed with a valid/ready handshake, and read data returns with a fixed-latency valid strobe and a per-burst done pulse. It sits between the image-processing IP and on-chip SPRAM, replacing per-word address driving.

Parameters:
NUM_BANKS, 4, number of SPRAM macros; legal values 1, 2, 4.
ADDR_W, 32, width of cmd_addr (byte address).
LEN_W, 16, width of cmd_len (burst length in 16-bit words).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  start byte address; bit 0 ignored
cmd_len  in  LEN_W  number of words; 0 = no-op
wr_data  in  16  write beat data
wr_valid  in  1  write beat offered
wr_ready  out  1  controller can take a write beat
rd_data  out  16  read beat data, registered
rd_valid  out  1  rd_data valid this cycle; no backpressure
busy  out  1  burst in progress or read data in flight
done  out  1  one-cycle pulse at burst completion

Behaviour:
- Word address WA = cmd_addr[14+log2(NUM_BANKS):1]. Bank = WA upper log2(NUM_BANKS) bits (none when NUM_BANKS=1). Macro address = WA[13:0]. Higher cmd_addr bits are ignored.
- WA increments by 1 per beat, modulo NUM_BANKS*16384. Bursts cross bank boundaries and wrap the top of memory without gaps.
- Only the selected bank's WREN is asserted. MASKWREN=4'b1111, CHIPSELECT=1, STANDBY=0, SLEEP=0, POWEROFF=1.
- FSM states:
  - IDLE: cmd_ready=1. On accept with cmd_len=0, go to IDLE and pulse done next cycle. With cmd_write=1, go to WRITE. Otherwise go to READ. Latch WA and remaining = cmd_len.
  - WRITE: wr_ready=1. Each cycle with wr_valid, write wr_data to the current WA, increment WA and decrement remaining. Cycles without wr_valid stall the burst with no side effects. The last beat returns to IDLE, and done pulses the following cycle.
  - READ: issue one read per cycle unconditionally. The last issue returns to IDLE.
- Read latency: a beat issued in cycle N gives rd_valid=1 and rd_data in cycle N+2 (SPRAM output plus output register). The bank select is pipelined with the read, so a bank crossing never mixes data.
- A "last" tag travels with each read; done pulses in the same cycle as the last rd_valid.
- A new command may be accepted in the cycle after a read burst's last issue, while its data is still in flight. Ordering of rd_valid beats is preserved, and a subsequent write never corrupts the in-flight reads.
- busy = (state != IDLE) || any read in the pipeline.
- cmd_ready is held 0 while done is being generated for a 0-length command.
- Reset values: state IDLE, cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0.
- Reset mid-burst: abort immediately and clear the read pipeline (no rd_valid or done afterwards). Words already written stay written; memory contents are otherwise untouched.

Test Plan:
1. Single write then read: write cmd_addr=0x0010, len=1, data 0xBEEF; then read the same address, len=1. Expect rd_valid exactly 2 cycles after issue with rd_data=0xBEEF, and done coincident with rd_valid.
2. Bank-crossing burst: write len=4 at byte 0x7FFC with data 1,2,3,4 (WA 0x3FFE..0x4001 spans banks 0 and 1), then read back. Expect 1,2,3,4 on four consecutive rd_valid cycles.
3. Top wrap, NUM_BANKS=4: write len=2 at byte 0x1FFFE with data 0xAAAA, 0x5555. Expect WA 0xFFFF then 0x0000; reading byte 0x0000 returns 0x5555.
4. Write with gaps: len=3 with wr_valid toggled 1,0,0,1,0,1. Expect exactly 3 writes and done one cycle after the third accepted beat; readback matches.
5. Back-to-back: read len=8 immediately followed by write len=1 to the first address of that read. Expect eight rd_valid beats carrying the old data in order, and the new data present on a later read.
6. Edge cases: cmd_len=0 gives done one cycle after accept with no rd_valid and no write. Asserting reset during the 3rd beat of a read len=8 gives no further rd_valid or done, and busy=0 and cmd_ready=1 immediately.
